ln_stat_writer: RTL
===================

// Module: ln_stat_writer
// PURPOSE
// Write-side initiator of the layer_norm statistics LUT port (lut_wen/lut_addr/lut_wdata/lut_ren).
// Consumes the same integer activation beats that feed layer_norm. Reduces each token of LN_NUM
// elements to a signed sum and a sum of squares, and writes one packed word per token at address
// = token index. Sits beside layer_norm in the vector engine and fills the LUT before the normalise pass.
// PARAMETERS
// DATA_DEPTH  `ARR_GBUS_DATA/`ARR_IDATA_BIT  elements per input beat
// INT_WIDTH   `ARR_IDATA_BIT  signed element width
// FP_WIDTH    `LN_FP_W        width of each half of the LUT word
// LN_NUM      `N_MODEL        elements per token; multiple of DATA_DEPTH
// LUT_DEPTH   `SEQ_LENGTH     LUT entries (tokens)
// SUM_SHIFT   0               arithmetic right shift applied to the sum before saturation
// SQ_SHIFT    0               arithmetic right shift applied to the sum of squares before saturation
// PORTS
// clk         in   1                       clock
// rst_n       in   1                       asynchronous active-low reset
// clear       in   1                       sync: drop partial token, token index -> 0
// valid_in    in   1                       input_data beat valid
// input_data  in   DATA_DEPTH*INT_WIDTH    signed elements, packed [DATA_DEPTH-1:0][INT_WIDTH-1:0]
// n_tokens    in   $clog2(LUT_DEPTH)+1     tokens per pass; sampled on the first beat of token 0
// lut_wen     out  1                       one-cycle LUT write strobe
// lut_addr    out  $clog2(LUT_DEPTH)      token index
// lut_wdata   out  2*FP_WIDTH             {sumsq_sat, sum_sat}
// lut_ren     out  1                       tied 0; this block never reads
// done        out  1                       pulse coincident with the write of token n_tokens-1
// sat_flag    out  1                       sticky: any half saturated since the last clear or reset
// wrap_flag   out  1                       sticky: token index wrapped LUT_DEPTH-1 -> 0
// BEHAVIOUR
// - Reset: every output 0, FSM=IDLE, beat count=0, token index=0.
// - BEATS = LN_NUM/DATA_DEPTH. The beat counter advances only on valid_in. Gaps between beats are legal.
// - FSM IDLE -> ACCUM on valid_in. ACCUM -> IDLE on the last beat with no new beat. Stays in ACCUM when tokens arrive back-to-back.
// - Pipeline, 3 stages. S1 registers the per-beat reduction: sum of elements and sum of squares.
//   S2 is the accumulator. On a first beat it loads the S1 values, with no clear bubble; otherwise it adds.
//   S3 is the output register: shift, then signed saturate to FP_WIDTH, then drive the write.
// - Latency: lut_wen is high exactly 3 cycles after the cycle in which the token's last valid_in was high. It is high for 1 cycle.
// - Throughput: one token per BEATS cycles with no stalls. The LUT port accepts every write (no backpressure).
// - Widths: beat sum is INT_WIDTH+$clog2(DATA_DEPTH) bits. Accumulated sum is INT_WIDTH+$clog2(LN_NUM)+1 bits.
//   Sum of squares is 2*INT_WIDTH+$clog2(LN_NUM) bits. No internal overflow is possible.
// - Saturation: clamp to [-2^(FP_WIDTH-1), 2^(FP_WIDTH-1)-1]. Any clamp sets sat_flag.
// - After each write the token index increments. At LUT_DEPTH-1 it wraps to 0 and sets wrap_flag.
// - done pulses with the write whose lut_addr equals n_tokens-1. The token index continues from there (no auto-rewind).
// - clear has priority over valid_in in the same cycle: that beat is dropped.
//   A write already in S2/S3 still completes. sat_flag and wrap_flag are cleared.
// - Reset mid-token: the partial token is lost and no write is issued.
// STRUCTURE
// - Package ln_stat_pkg holds localparams BEATS, SUM_W, SQ_W, ADDR_W and the function sat_fp(value, shift).
// - Sub-module ln_beat_reduce: adder tree giving {beat_sum, beat_sumsq} over DATA_DEPTH elements. It contains the S1 register.
// TESTING (DATA_DEPTH=16, LN_NUM=64 -> 4 beats, FP_WIDTH=16, LUT_DEPTH=8, shifts 0)
// - All elements +1 for 4 beats -> lut_wen 3 cycles after beat 4, lut_addr=0, lut_wdata={16'd64,16'd64}.
// - All elements -128 -> sum -8192, sumsq 1048576 clamped -> lut_wdata={16'h7FFF,16'hE000}, sat_flag=1.
// - 3 tokens back-to-back, values 1,2,3 -> writes at addr 0,1,2 spaced 4 cycles apart.
//   Sums are 64/128/192. done pulses with addr 2 when n_tokens=3.
// - 9 tokens -> ninth write at addr 0, wrap_flag=1 from the eighth write onward.
// - rst_n low after 2 beats, then 4 beats of +2 -> single write at addr 0 with sum 128, sumsq 256.
//   clear after 2 beats -> same result.
// - Random gaps in valid_in (0-3 idle cycles) -> sums identical to the gapless run. Each write 3 cycles after that token's last beat.

Source files
------------

// File: rtl/ln_stat_writer_pkg.sv
// Shared configuration, derived widths and the FP-half saturation helper for the
// layer_norm statistics writer.
package ln_stat_pkg;

  localparam int CFG_DATA_DEPTH = 16;
  localparam int CFG_INT_WIDTH  = 8;
  localparam int CFG_FP_W       = 16;
  localparam int CFG_LN_NUM     = 64;
  localparam int CFG_LUT_DEPTH  = 8;

  localparam int BEATS  = CFG_LN_NUM / CFG_DATA_DEPTH;
  localparam int BSUM_W = CFG_INT_WIDTH + $clog2(CFG_DATA_DEPTH);
  localparam int BSQ_W  = 2 * CFG_INT_WIDTH + $clog2(CFG_DATA_DEPTH);
  localparam int SUM_W  = CFG_INT_WIDTH + $clog2(CFG_LN_NUM) + 1;
  localparam int SQ_W   = 2 * CFG_INT_WIDTH + $clog2(CFG_LN_NUM);
  localparam int ADDR_W = $clog2(CFG_LUT_DEPTH);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [63:0] FP_MAX = (64'sd1 <<< (CFG_FP_W - 1)) - 64'sd1;
  localparam logic signed [63:0] FP_MIN = -(64'sd1 <<< (CFG_FP_W - 1));

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } ln_state_e;

  typedef struct packed {
    logic                sat;
    logic [CFG_FP_W-1:0] val;
  } sat_res_t;

  // Arithmetic shift, then clamp into one signed FP_W half; sat flags a clamp.
  function automatic sat_res_t sat_fp(input logic signed [63:0] value, input int shift);
    logic signed [63:0] sh;
    sat_res_t           r;
    sh    = value >>> shift;
    r.sat = 1'b1;
    if (sh > FP_MAX) begin
      r.val = FP_MAX[CFG_FP_W-1:0];
    end else if (sh < FP_MIN) begin
      r.val = FP_MIN[CFG_FP_W-1:0];
    end else begin
      r.sat = 1'b0;
      r.val = sh[CFG_FP_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ln_stat_writer_beat_reduce.sv
// Per-beat reduction of DATA_DEPTH signed elements to {sum, sum of squares},
// registered as pipeline stage 1.
module ln_beat_reduce
  import ln_stat_pkg::*;
#(
  parameter int DATA_DEPTH = CFG_DATA_DEPTH,
  parameter int INT_WIDTH  = CFG_INT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 vld_p0,
  input  logic [DATA_DEPTH-1:0][INT_WIDTH-1:0] data_p0,
  output logic                                 vld_p1,
  output logic signed [BSUM_W-1:0]             beat_sum_p1,
  output logic signed [BSQ_W-1:0]              beat_sumsq_p1
);

  logic signed [BSUM_W-1:0]      sum_d, sum_q;
  logic signed [BSQ_W-1:0]       sq_d, sq_q;
  logic signed [INT_WIDTH-1:0]   elem;
  logic signed [2*INT_WIDTH-1:0] prod;
  logic                          vld_d, vld_q;

  always_comb begin
    sum_d = '0;
    sq_d  = '0;
    elem  = '0;
    prod  = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      elem  = signed'(data_p0[i]);
      prod  = (2*INT_WIDTH)'(elem) * (2*INT_WIDTH)'(elem);
      sum_d = sum_d + BSUM_W'(elem);
      sq_d  = sq_d + BSQ_W'(prod);
    end
    vld_d = vld_p0;
  end

  // ---- stage 1 boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sum_q <= sum_d;
      sq_q  <= sq_d;
    end
  end

  assign vld_p1        = vld_q;
  assign beat_sum_p1   = sum_q;
  assign beat_sumsq_p1 = sq_q;

endmodule

// File: rtl/ln_stat_writer.sv
// Reduces each token of activation beats to {sum, sum of squares} and writes one
// saturated packed word per token into the layer_norm statistics LUT.
module ln_stat_writer
  import ln_stat_pkg::*;
#(
  parameter int DATA_DEPTH = CFG_DATA_DEPTH,
  parameter int INT_WIDTH  = CFG_INT_WIDTH,
  parameter int FP_WIDTH   = CFG_FP_W,
  parameter int LN_NUM     = CFG_LN_NUM,
  parameter int LUT_DEPTH  = CFG_LUT_DEPTH,
  parameter int SUM_SHIFT  = 0,
  parameter int SQ_SHIFT   = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              valid_in,
  input  logic [DATA_DEPTH*INT_WIDTH-1:0]   input_data,
  input  logic [$clog2(LUT_DEPTH):0]        n_tokens,
  output logic                              lut_wen,
  output logic [$clog2(LUT_DEPTH)-1:0]      lut_addr,
  output logic [2*FP_WIDTH-1:0]             lut_wdata,
  output logic                              lut_ren,
  output logic                              done,
  output logic                              sat_flag,
  output logic                              wrap_flag
);

  ln_state_e                state_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]        tok_q, tok_d;
  logic [ADDR_W:0]          n_tok_q, n_tok_d;
  logic                     accept, first_beat, last_beat;

  logic                     vld_p1;
  logic signed [BSUM_W-1:0] beat_sum_p1;
  logic signed [BSQ_W-1:0]  beat_sumsq_p1;
  logic                     first_p1_q, first_p1_d, last_p1_q, last_p1_d;
  logic [ADDR_W-1:0]        addr_p1_q, addr_p1_d;

  logic                     vld_p2_q, vld_p2_d;
  logic signed [SUM_W-1:0]  acc_sum_p2_q, acc_sum_p2_d;
  logic signed [SQ_W-1:0]   acc_sq_p2_q, acc_sq_p2_d;
  logic [ADDR_W-1:0]        addr_p2_q, addr_p2_d;

  sat_res_t                 sum_res, sq_res;
  logic                     lut_wen_q, lut_wen_d, done_q, done_d;
  logic [ADDR_W-1:0]        lut_addr_q, lut_addr_d;
  logic [2*FP_WIDTH-1:0]    lut_wdata_q, lut_wdata_d;
  logic                     sat_flag_q, sat_flag_d, wrap_flag_q, wrap_flag_d;

  // clear wins over a same-cycle beat, which is dropped
  assign accept     = valid_in & ~clear;
  assign first_beat = (state_q == ST_IDLE) || (cnt_q == '0);
  assign last_beat  = (cnt_q == CNT_W'(LN_NUM / DATA_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_q <= ST_ACCUM;
        ST_ACCUM: if (clear || (cnt_q == '0 && !valid_in)) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    tok_d   = tok_q;
    n_tok_d = n_tok_q;
    if (clear) begin
      cnt_d = '0;
      tok_d = '0;
    end else if (valid_in) begin
      if (first_beat && tok_q == '0) n_tok_d = n_tokens;
      if (last_beat) begin
        cnt_d = '0;
        tok_d = (tok_q == ADDR_W'(LUT_DEPTH - 1)) ? '0 : tok_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  ln_beat_reduce #(
    .DATA_DEPTH (DATA_DEPTH),
    .INT_WIDTH  (INT_WIDTH)
  ) u_reduce (
    .clk           (clk),
    .rst_n         (rst_n),
    .vld_p0        (accept),
    .data_p0       (input_data),
    .vld_p1        (vld_p1),
    .beat_sum_p1   (beat_sum_p1),
    .beat_sumsq_p1 (beat_sumsq_p1)
  );

  always_comb begin
    first_p1_d = first_p1_q;
    last_p1_d  = last_p1_q;
    addr_p1_d  = addr_p1_q;
    if (accept) begin
      first_p1_d = first_beat;
      last_p1_d  = last_beat;
      addr_p1_d  = tok_q;
    end
    // ---- stage 2 boundary: first beat loads, so no bubble between tokens ----
    acc_sum_p2_d = acc_sum_p2_q;
    acc_sq_p2_d  = acc_sq_p2_q;
    addr_p2_d    = addr_p2_q;
    if (vld_p1) begin
      acc_sum_p2_d = first_p1_q ? SUM_W'(beat_sum_p1) : acc_sum_p2_q + SUM_W'(beat_sum_p1);
      acc_sq_p2_d  = first_p1_q ? SQ_W'(beat_sumsq_p1) : acc_sq_p2_q + SQ_W'(beat_sumsq_p1);
      addr_p2_d    = addr_p1_q;
    end
    vld_p2_d = vld_p1 & last_p1_q;
    // ---- stage 3 boundary ----
    sum_res     = sat_fp(64'(acc_sum_p2_q), SUM_SHIFT);
    sq_res      = sat_fp(64'(acc_sq_p2_q), SQ_SHIFT);
    lut_wen_d   = vld_p2_q;
    lut_addr_d  = vld_p2_q ? addr_p2_q : lut_addr_q;
    lut_wdata_d = vld_p2_q ? {sq_res.val, sum_res.val} : lut_wdata_q;
    done_d      = vld_p2_q && ({1'b0, addr_p2_q} == n_tok_q - 1'b1);
    sat_flag_d  = (sat_flag_q & ~clear) | (vld_p2_q & (sum_res.sat | sq_res.sat));
    wrap_flag_d = (wrap_flag_q & ~clear) | (vld_p2_q && addr_p2_q == ADDR_W'(LUT_DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    first_p1_q   <= first_p1_d;
    last_p1_q    <= last_p1_d;
    addr_p1_q    <= addr_p1_d;
    acc_sum_p2_q <= acc_sum_p2_d;
    acc_sq_p2_q  <= acc_sq_p2_d;
    addr_p2_q    <= addr_p2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      tok_q       <= '0;
      n_tok_q     <= '0;
      vld_p2_q    <= 1'b0;
      lut_wen_q   <= 1'b0;
      lut_addr_q  <= '0;
      lut_wdata_q <= '0;
      done_q      <= 1'b0;
      sat_flag_q  <= 1'b0;
      wrap_flag_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tok_q       <= tok_d;
      n_tok_q     <= n_tok_d;
      vld_p2_q    <= vld_p2_d;
      lut_wen_q   <= lut_wen_d;
      lut_addr_q  <= lut_addr_d;
      lut_wdata_q <= lut_wdata_d;
      done_q      <= done_d;
      sat_flag_q  <= sat_flag_d;
      wrap_flag_q <= wrap_flag_d;
    end
  end

  assign lut_wen   = lut_wen_q;
  assign lut_addr  = lut_addr_q;
  assign lut_wdata = lut_wdata_q;
  assign lut_ren   = 1'b0;
  assign done      = done_q;
  assign sat_flag  = sat_flag_q;
  assign wrap_flag = wrap_flag_q;

endmodule
